lc3_mem_ctrl: RTL and testbench
===============================

# lc3_mem_ctrl

Memory-access stage of the LC-3 datapath, directly downstream of the address-select adder. It latches the computed effective address into MAR, holds data in MDR, and runs a req/ack handshake to data memory on behalf of the control FSM. It returns the LC-3 "R" (ready) signal and exposes MAR and MDR to the bus gates.

## Interface
Parameters:
- `IO_BASE`, default 16'hFE00: lowest address routed to the I/O port when MMIO is compiled in.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `ld_mar`  in  1  load MAR from `addr_in`
- `addr_in`  in  16  effective address from the address-select adder (MARMUX path)
- `ld_mdr`  in  1  load MDR from `bus_in`; effective only when `mio_en`=0
- `bus_in`  in  16  processor bus value
- `mio_en`  in  1  request a memory access
- `r_w`  in  1  0 = read, 1 = write
- `mem_ready`  out  1  LC-3 R signal; access complete
- `mar_out`  out  16  MAR contents
- `mdr_out`  out  16  MDR contents, driving GateMDR
- `mem_req`  out  1  memory request
- `mem_we`  out  1  memory write enable, qualified by `mem_req`
- `mem_addr`  out  16  memory address, equal to MAR
- `mem_wdata`  out  16  write data, equal to MDR
- `mem_rdata`  in  16  read data, valid when `mem_ack`=1
- `mem_ack`  in  1  memory completion
- `io_req`  out  1  I/O request
- `io_ack`  in  1  I/O completion
- `io_rdata`  in  16  I/O read data

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- Reset values: MAR=0, MDR=0, `mem_req`=0, `io_req`=0, `mem_we`=0, `mem_ready`=0.
- **IDLE**
  - `ld_mar` loads MAR from `addr_in`.
  - `ld_mdr` with `mio_en`=0 loads MDR from `bus_in`.
  - `mio_en`=1 latches `r_w` and enters REQ.
  - If `ld_mar` and `mio_en` are both high in the same IDLE cycle, MAR loads first and the access uses the new address.
- **REQ**
  - `mem_req` (or `io_req`) is registered high, and `mem_we` = latched `r_w`.
  - MAR and MDR are frozen. `ld_mar` and `ld_mdr` are ignored.
  - The FSM waits indefinitely for the selected ack. Acks from the non-selected target are ignored.
  - On ack:
    - A read loads MDR from `mem_rdata`/`io_rdata`.
    - `req` drops on the next edge.
    - The FSM enters DONE.
- **DONE**
  - `mem_ready`=1.
  - Stays in DONE until `mio_en` is sampled 0, then goes to IDLE. This prevents a held `mio_en` from re-triggering the access.
  - `ld_mar`/`ld_mdr` are accepted in DONE, with the same rules as IDLE.
- Width rules: all data paths are 16-bit with no arithmetic. The address compare is unsigned `MAR >= IO_BASE`.
- `mio_en` dropped while in REQ: the access still completes, then DONE exits immediately to IDLE on the next edge.
- Reset asserted mid-access: immediate return to IDLE with all outputs at reset values. Memory must tolerate an abandoned request.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Zero-wait memory:
  - `mio_en` sampled at edge 0.
  - `mem_req` high in cycle 1; `mem_ack`=1 in cycle 1.
  - MDR and `mem_ready` valid in cycle 2.
  - Minimum latency is 2 cycles from `mio_en` to R.
- Each wait cycle of `mem_ack` adds one cycle.
- `mem_req` is high for exactly (wait + 1) cycles per access.
- Back-to-back accesses require at least one cycle with `mio_en`=0.

## Configuration
- `LC3_MMIO_EN` defined:
  - Accesses with MAR ≥ `IO_BASE` assert `io_req` instead of `mem_req` and complete on `io_ack`.
  - Read data comes from `io_rdata`.
  - `mem_we` stays 0 for I/O accesses; the write flag is carried on `io_req` with `mem_we` semantics mirrored.
- `LC3_MMIO_EN` undefined:
  - All addresses go to memory.
  - `io_req` is tied 0, and `io_ack`/`io_rdata` are ignored.

## Structure
- Shared package `lc3_pkg`:
  - state enum `mem_state_t` {IDLE, REQ, DONE}
  - `LC3_WORD_W`=16
  - `LC3_IO_BASE`=16'hFE00
- Single flat module; no sub-module is needed. The MAR/MDR registers and FSM sit in one file.

## Test plan
- Read, zero wait: MAR←16'h3000 via `ld_mar`; `mio_en`=1, `r_w`=0; `mem_ack`=1 immediately with `mem_rdata`=16'hBEEF → `mem_req` high for 1 cycle, MDR=16'hBEEF and `mem_ready`=1 two cycles after `mio_en`.
- Write, 3 wait states: MAR=16'h4001, MDR←16'h1234 via `ld_mdr`; `mio_en`=1, `r_w`=1 → `mem_req`=1 and `mem_we`=1 for 4 cycles with `mem_addr`=16'h4001 and `mem_wdata`=16'h1234; R after ack.
- Held `mio_en`: keep `mio_en` high for 5 cycles after R → exactly one `mem_req` pulse; R stays 1 until `mio_en` drops.
- Freeze: pulse `ld_mar` with 16'hFFFF during REQ → `mem_addr` is unchanged and MAR is unchanged after completion.
- Reset mid-access: assert `reset_n`=0 in REQ cycle 2 → `mem_req`=0, MAR=0, MDR=0, state IDLE; the next access behaves normally.
- MMIO (`LC3_MMIO_EN`): read of MAR=16'hFE00 with `io_rdata`=16'h8000 → `io_req`=1, `mem_req`=0, MDR=16'h8000. Without the macro, the same access asserts `mem_req`.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants.
package lc3_pkg;
  localparam int          LC3_WORD_W  = 16;
  localparam logic [15:0] LC3_IO_BASE = 16'hFE00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;
endpackage

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory-access stage: MAR/MDR registers and req/ack handshake; all outputs registered.
// Optional memory-mapped I/O routing when LC3_MMIO_EN is defined.
module lc3_mem_ctrl
  import lc3_pkg::*;
#(
  parameter logic [LC3_WORD_W-1:0] IO_BASE = LC3_IO_BASE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ld_mar,
  input  logic [LC3_WORD_W-1:0] addr_in,
  input  logic                  ld_mdr,
  input  logic [LC3_WORD_W-1:0] bus_in,
  input  logic                  mio_en,
  input  logic                  r_w,
  output logic                  mem_ready,
  output logic [LC3_WORD_W-1:0] mar_out,
  output logic [LC3_WORD_W-1:0] mdr_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [LC3_WORD_W-1:0] mem_addr,
  output logic [LC3_WORD_W-1:0] mem_wdata,
  input  logic [LC3_WORD_W-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  io_req,
  input  logic                  io_ack,
  input  logic [LC3_WORD_W-1:0] io_rdata
);

  mem_state_t            state_q, state_d;
  logic [LC3_WORD_W-1:0] mar_q, mar_d;
  logic [LC3_WORD_W-1:0] mdr_q, mdr_d;
  logic                  rw_q, rw_d;
  logic                  io_sel_q, io_sel_d;
  logic                  mem_req_q, mem_req_d;
  logic                  io_req_q, io_req_d;
  logic                  mem_we_q, mem_we_d;
  logic                  ready_q, ready_d;

  logic [LC3_WORD_W-1:0] next_mar;
  logic                  io_hit;
  logic                  acc_ack;
  logic [LC3_WORD_W-1:0] acc_rdata;

  // Target decode uses the address MAR will hold, so a same-cycle ld_mar steers the access.
  assign next_mar = ld_mar ? addr_in : mar_q;

`ifdef LC3_MMIO_EN
  assign io_hit    = (next_mar >= IO_BASE);
  assign acc_ack   = io_sel_q ? io_ack   : mem_ack;
  assign acc_rdata = io_sel_q ? io_rdata : mem_rdata;
`else
  logic unused_io;
  assign unused_io = ^{io_ack, io_rdata, io_sel_q};
  assign io_hit    = 1'b0;
  assign acc_ack   = mem_ack;
  assign acc_rdata = mem_rdata;
`endif

  always_comb begin
    state_d   = state_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    rw_d      = rw_q;
    io_sel_d  = io_sel_q;
    mem_req_d = mem_req_q;
    io_req_d  = io_req_q;
    mem_we_d  = mem_we_q;
    ready_d   = ready_q;

    unique case (state_q)
      IDLE: begin
        mar_d = next_mar;
        if (ld_mdr && !mio_en) mdr_d = bus_in;
        if (mio_en) begin
          state_d   = REQ;
          rw_d      = r_w;
          io_sel_d  = io_hit;
          mem_req_d = !io_hit;
          io_req_d  = io_hit;
          mem_we_d  = r_w && !io_hit;
        end
      end
      REQ: begin
        if (acc_ack) begin
          if (!rw_q) mdr_d = acc_rdata;
          state_d   = DONE;
          mem_req_d = 1'b0;
          io_req_d  = 1'b0;
          mem_we_d  = 1'b0;
          ready_d   = 1'b1;
        end
      end
      DONE: begin
        mar_d = next_mar;
        if (ld_mdr && !mio_en) mdr_d = bus_in;
        // Wait for mio_en to drop so a held request does not re-trigger.
        if (!mio_en) begin
          state_d = IDLE;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        io_req_d  = 1'b0;
        mem_we_d  = 1'b0;
        ready_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mar_q     <= '0;
      mdr_q     <= '0;
      rw_q      <= 1'b0;
      io_sel_q  <= 1'b0;
      mem_req_q <= 1'b0;
      io_req_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      rw_q      <= rw_d;
      io_sel_q  <= io_sel_d;
      mem_req_q <= mem_req_d;
      io_req_q  <= io_req_d;
      mem_we_q  <= mem_we_d;
      ready_q   <= ready_d;
    end
  end

  assign mem_ready = ready_q;
  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign io_req    = io_req_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_lc3_mem_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_mar, ld_mdr, mio_en, r_w, mem_ack, io_ack;
  logic [15:0] addr_in, bus_in, mem_rdata, io_rdata;
  logic        mem_ready, mem_req, mem_we, io_req;
  logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lc3_mem_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .ld_mar(ld_mar), .addr_in(addr_in), .ld_mdr(ld_mdr), .bus_in(bus_in),
    .mio_en(mio_en), .r_w(r_w), .mem_ready(mem_ready),
    .mar_out(mar_out), .mdr_out(mdr_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_req(io_req), .io_ack(io_ack), .io_rdata(io_rdata)
  );

  typedef struct {
    logic        ld_mar;
    logic [15:0] addr;
    logic        ld_mdr;
    logic [15:0] bus;
    logic        mio_en;
    logic        r_w;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        io_ack;
    logic        e_req;
    logic        e_we;
    logic        e_rdy;
    logic [15:0] e_mar;
    logic [15:0] e_mdr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lm, input logic [15:0] a, input logic ld, input logic [15:0] b,
                       input logic me, input logic rw, input logic ma, input logic [15:0] md,
                       input logic ia, input logic [15:0] id);
    @(negedge clk);
    ld_mar = lm; addr_in = a; ld_mdr = ld; bus_in = b;
    mio_en = me; r_w = rw; mem_ack = ma; mem_rdata = md; io_ack = ia; io_rdata = id;
    @(posedge clk);
    #1;
  endtask

  // Packs the externally visible outputs in a fixed order for compact comparison.
  function automatic logic [63:0] outs(input logic req, input logic ioq, input logic we, input logic rdy,
                                       input logic [15:0] mar, input logic [15:0] mdr);
    return {8'h0, 4'h0, req, ioq, we, rdy, mar, mdr, 16'h0};
  endfunction

  task automatic addv(input logic lm, input logic [15:0] a, input logic ld, input logic [15:0] b,
                      input logic me, input logic rw, input logic ma, input logic [15:0] md, input logic ia,
                      input logic er, input logic ew, input logic ey, input logic [15:0] emar,
                      input logic [15:0] emdr);
    vec_t v;
    v.ld_mar = lm; v.addr = a; v.ld_mdr = ld; v.bus = b; v.mio_en = me; v.r_w = rw;
    v.mem_ack = ma; v.mem_rdata = md; v.io_ack = ia;
    v.e_req = er; v.e_we = ew; v.e_rdy = ey; v.e_mar = emar; v.e_mdr = emdr;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0;
    ld_mar = 0; addr_in = 0; ld_mdr = 0; bus_in = 0; mio_en = 0; r_w = 0;
    mem_ack = 0; mem_rdata = 0; io_ack = 0; io_rdata = 0;

    //   lm addr     ld bus      me rw ma rdata    ia | req we rdy mar      mdr
    // Read, zero wait
    addv(1, 16'h3000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h3000, 16'h0000);
    addv(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0,  1, 0, 0, 16'h3000, 16'h0000);
    addv(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'hBEEF, 0,  0, 0, 1, 16'h3000, 16'hBEEF);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h3000, 16'hBEEF);
    // Write, 3 wait states; stray io_ack ignored while memory is selected
    addv(1, 16'h4001, 1, 16'h1234, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 0,  1, 1, 0, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 1,  1, 1, 0, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 0,  1, 1, 0, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 0,  1, 1, 0, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 1, 1, 16'hDEAD, 0,  0, 0, 1, 16'h4001, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h4001, 16'h1234);
    // Held mio_en: one req pulse, R held; ld_mar accepted on DONE exit
    addv(1, 16'h0050, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h0050, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0,  1, 0, 0, 16'h0050, 16'h1234);
    addv(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h0A0A, 0,  0, 0, 1, 16'h0050, 16'h0A0A);
    for (int i = 0; i < 5; i++)
      addv(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h9999, 0,  0, 0, 1, 16'h0050, 16'h0A0A);
    addv(1, 16'h1111, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h1111, 16'h0A0A);
    // mio_en dropped during REQ
    addv(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0,  1, 0, 0, 16'h1111, 16'h0A0A);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  1, 0, 0, 16'h1111, 16'h0A0A);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h5555, 0,  0, 0, 1, 16'h1111, 16'h5555);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h1111, 16'h5555);
    // ld_mar with mio_en in the same cycle uses the new address
    addv(1, 16'h2222, 0, 16'h0000, 1, 0, 0, 16'h0000, 0,  1, 0, 0, 16'h2222, 16'h5555);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h7777, 0,  0, 0, 1, 16'h2222, 16'h7777);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h2222, 16'h7777);
    // ld_mdr with mio_en=1 is not a load; write keeps MDR
    addv(0, 16'h0000, 1, 16'hAAAA, 1, 1, 0, 16'h0000, 0,  1, 1, 0, 16'h2222, 16'h7777);
    addv(0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0000, 0,  0, 0, 1, 16'h2222, 16'h7777);
    addv(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0,  0, 0, 0, 16'h2222, 16'h7777);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 0, 16'h0000, 16'h0000));
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld_mar, vecs[i].addr, vecs[i].ld_mdr, vecs[i].bus, vecs[i].mio_en, vecs[i].r_w,
            vecs[i].mem_ack, vecs[i].mem_rdata, vecs[i].io_ack, 16'h0000);
      check($sformatf("vec%0d", i),
            outs(mem_req, io_req, mem_we, mem_ready, mem_addr, mem_wdata),
            outs(vecs[i].e_req, 1'b0, vecs[i].e_we, vecs[i].e_rdy, vecs[i].e_mar, vecs[i].e_mdr));
      check($sformatf("vec%0d_regs", i), {32'h0, mar_out, mdr_out},
            {32'h0, vecs[i].e_mar, vecs[i].e_mdr});
    end

    // Freeze: ld_mar/ld_mdr pulses during REQ are ignored
    drive(1, 16'h0123, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000);
    drive(1, 16'hFFFF, 1, 16'hCCCC, 1, 0, 0, 16'h0000, 0, 16'h0000);
    check("freeze_addr", {48'h0, mem_addr}, {48'h0, 16'h0123});
    check("freeze_mdr", {48'h0, mdr_out}, {48'h0, 16'h7777});
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h6060, 0, 16'h0000);
    check("freeze_done", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 1, 16'h0123, 16'h6060));
    drive(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000);

    // Reset mid-access in REQ cycle 2
    drive(1, 16'h0456, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000);
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000);
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000);
    check("pre_reset_req", {63'h0, mem_req}, 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_reset", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 0, 16'h0000, 16'h0000));
    @(negedge clk);
    mio_en = 0;
    reset_n = 1'b1;
    drive(1, 16'h0789, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000);
    check("post_reset_req", outs(mem_req, io_req, mem_we, mem_ready, mem_addr, mdr_out),
          outs(1, 0, 0, 0, 16'h0789, 16'h0000));
    drive(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h1357, 0, 16'h0000);
    check("post_reset_done", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 1, 16'h0789, 16'h1357));
    drive(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000);

    // Access at IO_BASE
    drive(1, 16'hFE00, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h8000);
`ifdef LC3_MMIO_EN
    check("mmio_req", {62'h0, io_req, mem_req}, {62'h0, 2'b10});
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h4242, 0, 16'h8000);
    check("mmio_memack_ignored", {62'h0, io_req, mem_ready}, {62'h0, 2'b10});
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'h8000);
    check("mmio_done", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 1, 16'hFE00, 16'h8000));
`else
    check("mmio_req", {62'h0, io_req, mem_req}, {62'h0, 2'b01});
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 16'h8000);
    check("mmio_ioack_ignored", {62'h0, mem_req, mem_ready}, {62'h0, 2'b10});
    drive(0, 16'h0000, 0, 16'h0000, 1, 0, 1, 16'h4242, 1, 16'h8000);
    check("mmio_done", outs(mem_req, io_req, mem_we, mem_ready, mar_out, mdr_out),
          outs(0, 0, 0, 1, 16'hFE00, 16'h4242));
`endif
    drive(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000);
    check("final_idle", {62'h0, mem_ready, mem_req}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
